// File: rtl/fs_pkg.sv
// Shared stage state types and coefficient-fetch geometry for the inverse-transform datapath.
package fs_pkg;

  typedef enum logic [2:0] {
    S_FS_IDLE,
    S_FS_LI_1,
    S_FS_LI_2,
    S_FS_LI_3,
    S_FS_CC,
    S_FS_LO_1,
    S_FS_LO_2,
    S_FS_LO_3
  } FS_state_type;

  typedef enum logic [1:0] {
    FS_SEG_Y,
    FS_SEG_U,
    FS_SEG_V
  } fs_seg_t;

  localparam logic [17:0] FS_Y_BASE = 18'd76800;
  localparam logic [17:0] FS_U_BASE = 18'd153600;
  localparam logic [17:0] FS_V_BASE = 18'd192000;

  localparam int unsigned FS_Y_STRIDE  = 320;
  localparam int unsigned FS_UV_STRIDE = 160;

  localparam logic [5:0] FS_Y_C_END  = 6'd39;
  localparam logic [5:0] FS_UV_C_END = 6'd19;
  localparam logic [4:0] FS_R_END    = 5'd29;

  function automatic logic [5:0] fs_c_end(input fs_seg_t seg);
    return (seg == FS_SEG_Y) ? FS_Y_C_END : FS_UV_C_END;
  endfunction

  function automatic fs_seg_t fs_next_seg(input fs_seg_t seg);
    case (seg)
      FS_SEG_Y: return FS_SEG_U;
      FS_SEG_U: return FS_SEG_V;
      default:  return FS_SEG_Y;
    endcase
  endfunction

endpackage

// File: rtl/fs_addr_gen.sv
// Combinational SRAM address for one coefficient: segment base + block row/column + element.
module fs_addr_gen
  import fs_pkg::*;
(
  input  fs_seg_t     seg,
  input  logic [4:0]  rb,
  input  logic [5:0]  cb,
  input  logic [5:0]  ec,
  output logic [17:0] addr
);

  logic [17:0] ra;
  logic [17:0] ca;
  logic [17:0] base;
  logic [17:0] row_off;

  always_comb begin
    ra = {10'd0, rb, ec[5:3]};
    ca = {9'd0, cb, ec[2:0]};
    case (seg)
      FS_SEG_U: base = FS_U_BASE;
      FS_SEG_V: base = FS_V_BASE;
      default:  base = FS_Y_BASE;
    endcase
    // Row stride as shift-add: 320 = 256 + 64, 160 = 128 + 32.
    if (seg == FS_SEG_Y) row_off = (ra << 8) + (ra << 6);
    else                 row_off = (ra << 7) + (ra << 5);
    addr = base + row_off + ca;
  end

endmodule

// File: rtl/fs_fetch.sv
// Fetches one 8x8 block of signed 16-bit coefficients from SRAM into the DPRAM per FS_start.
// Optional FS_PINGPONG_EN alternates consecutive blocks between DPRAM halves 0..63 / 64..127.
module fs_fetch
  import fs_pkg::*;
(
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        FS_start,
  output logic        FS_done,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic [6:0]  s_write_address,
  output logic [31:0] s_write_data,
  output logic        s_write_enable
);

  FS_state_type state, state_n;
  fs_seg_t      seg;
  logic [4:0]   rb;
  logic [5:0]   cb;
  logic [5:0]   ec;
  logic [5:0]   wc;
  logic         bank;
  logic [17:0]  addr_next;
  logic         iss_en;
  logic         wr_en;

  assign SRAM_we_n = 1'b1;

  fs_addr_gen u_addr_gen (
    .seg  (seg),
    .rb   (rb),
    .cb   (cb),
    .ec   (ec),
    .addr (addr_next)
  );

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) state <= S_FS_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    iss_en  = 1'b0;
    wr_en   = 1'b0;
    case (state)
      S_FS_IDLE: if (FS_start) state_n = S_FS_LI_1;
      S_FS_LI_1: begin iss_en = 1'b1; state_n = S_FS_LI_2; end
      S_FS_LI_2: begin iss_en = 1'b1; state_n = S_FS_LI_3; end
      S_FS_LI_3: begin iss_en = 1'b1; state_n = S_FS_CC;   end
      S_FS_CC: begin
        wr_en = 1'b1;
        // ec wraps to 0 right after element 63 is issued; that cycle still carries a write.
        if (ec == 6'd0) state_n = S_FS_LO_1;
        else            iss_en  = 1'b1;
      end
      S_FS_LO_1: begin wr_en = 1'b1; state_n = S_FS_LO_2; end
      S_FS_LO_2: begin wr_en = 1'b1; state_n = S_FS_LO_3; end
      S_FS_LO_3: state_n = S_FS_IDLE;
      default:   state_n = S_FS_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      ec              <= '0;
      wc              <= '0;
      cb              <= '0;
      rb              <= '0;
      seg             <= FS_SEG_Y;
      SRAM_address    <= '0;
      s_write_address <= '0;
      s_write_data    <= '0;
      s_write_enable  <= 1'b0;
      FS_done         <= 1'b0;
    end else begin
      s_write_enable <= wr_en;
      FS_done        <= (state == S_FS_LO_3);
      if (iss_en) begin
        SRAM_address <= addr_next;
        ec           <= ec + 6'd1;
      end
      if (wr_en) begin
        s_write_address <= {bank, wc};
        s_write_data    <= {{16{SRAM_read_data[15]}}, SRAM_read_data};
        wc              <= wc + 6'd1;
      end
      if (state == S_FS_LO_3) begin
        if (cb == fs_c_end(seg)) begin
          cb <= '0;
          if (rb == FS_R_END) begin
            rb  <= '0;
            seg <= fs_next_seg(seg);
          end else begin
            rb <= rb + 5'd1;
          end
        end else begin
          cb <= cb + 6'd1;
        end
      end
    end
  end

`ifdef FS_PINGPONG_EN
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn)                 bank <= 1'b0;
    else if (state == S_FS_LO_3) bank <= ~bank;
  end
`else
  assign bank = 1'b0;
`endif

endmodule

// File: doc/fs_fetch.md
# fs_fetch

Upstream stage of the inverse-transform datapath. On each `FS_start` pulse it reads one 8x8 block of 16-bit signed pre-IDCT coefficients from external SRAM and writes the block, sign-extended to 32 bits, into the embedded dual-port RAM. The transform stages then consume that RAM, and the pixel write-back stage finally stores the result to SRAM. Block position (row, column and Y/U/V segment) is tracked internally and advances after every block, so the controller only issues start pulses.

## Interface
Parameters:
- none; geometry is fixed by package constants.

Ports:
- `CLOCK_50_I`  in  1  — 50 MHz clock; all logic on the rising edge.
- `Resetn`  in  1  — reset, asynchronous, active-low.
- `FS_start`  in  1  — start one block fetch; sampled only in `S_FS_IDLE`.
- `FS_done`  out  1  — one-cycle pulse when the block is fully written to DPRAM.
- `SRAM_address`  out  18  — SRAM read address.
- `SRAM_we_n`  out  1  — held at 1; this block never writes SRAM.
- `SRAM_read_data`  in  16  — SRAM read data, two's-complement coefficient.
- `s_write_address`  out  7  — DPRAM write address.
- `s_write_data`  out  32  — DPRAM write data.
- `s_write_enable`  out  1  — DPRAM write strobe.

## Operation
- Coefficient segment bases:
  - Y = 76800, row stride 320 words, 40x30 blocks.
  - U = 153600, row stride 160 words, 20x30 blocks.
  - V = 192000, row stride 160 words, 20x30 blocks.
- Element counter `EC` (6 bits) runs 0..63, with `r = EC[5:3]` and `c = EC[2:0]`. `RA = {RB, r}` and `CA = {CB, c}`.
- SRAM address:
  - Y: `base + (RA<<8) + (RA<<6) + CA`.
  - U/V: `base + (RA<<7) + (RA<<5) + CA`.
  - All terms are zero-extended to 18 bits; no overflow is possible (maximum 230399).
- DPRAM write:
  - Address = `{bank, r, c}`.
  - Data = `{{16{SRAM_read_data[15]}}, SRAM_read_data}`.
- States:
  - `S_FS_IDLE`: waits for `FS_start` → `S_FS_LI_1`.
  - `S_FS_LI_1`, `S_FS_LI_2`, `S_FS_LI_3`: lead-in; each issues the next address.
  - `S_FS_CC`: issues the remaining addresses and writes the element arriving from SRAM; exits once the last address is issued → `S_FS_LO_1`.
  - `S_FS_LO_1`, `S_FS_LO_2`, `S_FS_LO_3`: lead-out; write the final three elements.
  - After `S_FS_LO_3` → `S_FS_IDLE`.
- Block advance, done in `S_FS_LO_3`:
  - `CB` increments.
  - At `C_END` (39 for Y, 19 for U/V): `CB` → 0 and `RB` increments.
  - At `RB` = 29: `RB` → 0 and the segment advances Y→U→V→Y (wrap back to Y block 0,0).
- `FS_start` is ignored in every state except `S_FS_IDLE`.

## Timing
- SRAM read latency is fixed at 3 cycles: data for the address registered at edge k is sampled at edge k+3.
- With `FS_start` sampled at edge 0:
  - Addresses for elements 0..63 are registered at edges 1..64.
  - `s_write_enable` is high with element n registered at edge n+4, for exactly 64 consecutive cycles.
  - The last write completes at edge 68.
  - `FS_done` is registered high at edge 68 and cleared at edge 69.
- Start-to-done latency is therefore 68 cycles. A new `FS_start` is accepted at edge 69 at the earliest.
- Reset values:
  - `SRAM_address` = 0, `SRAM_we_n` = 1.
  - `s_write_address` = 0, `s_write_data` = 0, `s_write_enable` = 0.
  - `FS_done` = 0.
  - State `S_FS_IDLE`; `EC`, `CB`, `RB` = 0; segment = Y; bank = 0.
- Reset mid-block aborts the fetch immediately. No further DPRAM writes occur, no `FS_done` is produced, and the block position returns to Y (0,0).

## Configuration
- `FS_PINGPONG_EN`:
  - Defined: the `bank` bit (DPRAM address bit 6) toggles in `S_FS_LO_3` after every block, so consecutive blocks land at 0..63 and 64..127.
  - Undefined: `bank` is constant 0 and every block is written to addresses 0..63.

## Structure
- Shared state package: the `FS_state_type` enum, alongside the existing stage state types.
- Shared constants package:
  - Segment bases `FS_Y_BASE`, `FS_U_BASE`, `FS_V_BASE`.
  - Strides 320 and 160.
  - Column limits 39 and 19, and row limit 29.
- Sub-module: `fs_addr_gen`, a combinational mapping from (segment, `RB`, `CB`, `EC`) to the 18-bit SRAM address. Everything else stays in `fs_fetch`.

## Test plan
- Reset, then `FS_start` (first block):
  - Addresses 76800..76807, 77120..77127, …, 79040..79047.
  - DPRAM word k holds the SRAM word at the k-th address.
  - `FS_done` at cycle 68.
- SRAM word 0x8001 → `s_write_data` = 0xFFFF8001. SRAM word 0x7FFF → 0x00007FFF.
- 40 starts:
  - The 40th block begins at address 76800 + 312 = 77112.
  - The 41st block begins at 76800 + 8·320 = 79360 (`RB` = 1, `CB` = 0).
- 1200 Y blocks, then the next start → first address 153600 (U stride 160). After 600 U blocks, the next start → 192000. After 600 V blocks, the next start → 76800.
- `FS_start` held high throughout a fetch → no restart, exactly 64 writes. With `FS_PINGPONG_EN`, the second block is written to addresses 64..127.
- `Resetn` low at cycle 30:
  - All outputs return to their reset values.
  - No `FS_done`.
  - The next fetch reads from 76800.
